// File: rtl/trace_mgmt_pkg.sv
// Shared types for the trace management channel mux: arbiter state,
// the per-beat packet flags carried through the skid buffer, and an index-width helper.
package trace_mgmt_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } skid_flags_t;

    localparam int FLAGS_W = $bits(skid_flags_t);

    // Width of a port index; never below one bit so single-port builds still elaborate.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_mgmt_skid_buffer.sv
// Two-entry registered Avalon-ST pipeline stage; each entry holds {data, channel, sop, eop}.
// Upstream ready depends only on occupancy, so it never follows out_ready combinationally.
module trace_mgmt_skid_buffer
    import trace_mgmt_pkg::*;
#(
    parameter int DATA_WIDTH    = 1,
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    localparam int ENTRY_W = DATA_WIDTH + CHANNEL_WIDTH + FLAGS_W;

    logic [ENTRY_W-1:0] r_entry0;
    logic [ENTRY_W-1:0] r_entry1;
    logic [1:0]         r_count;

    logic [ENTRY_W-1:0] w_inEntry;
    skid_flags_t        w_inFlags;
    skid_flags_t        w_outFlags;
    logic               w_push;
    logic               w_pop;

    assign w_inFlags = '{sop: in_startofpacket, eop: in_endofpacket};
    assign w_inEntry = {in_data, in_channel, w_inFlags};

    // Held low while reset is asserted so no source sees a grant during reset.
    assign in_ready  = reset_n & (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign {out_data, out_channel, w_outFlags} = r_entry0;
    assign out_startofpacket = w_outFlags.sop;
    assign out_endofpacket   = w_outFlags.eop;

    // Entry 0 is always the head; vacated entries are cleared so an empty stage shows zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push && !w_pop) begin
                if (r_count == 2'd0) begin
                    r_entry0 <= w_inEntry;
                end else begin
                    r_entry1 <= w_inEntry;
                end
            end else if (!w_push && w_pop) begin
                r_entry0 <= r_entry1;
                r_entry1 <= '0;
            end else if (w_push && w_pop) begin
                if (r_count == 2'd1) begin
                    r_entry0 <= w_inEntry;
                end else begin
                    r_entry0 <= r_entry1;
                    r_entry1 <= w_inEntry;
                end
            end
        end
    end

endmodule

// File: rtl/trace_mgmt_channel_mux.sv
// Packet-aware round-robin merge of NUM_CHANNELS single-channel streams into one
// channel-tagged stream; a port keeps the grant from SOP until its EOP is accepted.
module trace_mgmt_channel_mux
    import trace_mgmt_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int DATA_WIDTH    = 1,
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CHANNELS-1:0]          in_valid,
    output logic [NUM_CHANNELS-1:0]          in_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]          in_startofpacket,
    input  logic [NUM_CHANNELS-1:0]          in_endofpacket,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CHANNEL_WIDTH-1:0]         out_channel,
    output logic                             out_startofpacket,
    output logic                             out_endofpacket
);

    localparam int IDX_W = idxWidth(NUM_CHANNELS);

    mux_state_t        r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rrPtr;

    logic [IDX_W-1:0]         w_sel;
    logic [IDX_W-1:0]         w_port;
    logic                     w_anyValid;
    logic                     w_grantValid;
    logic                     w_space;
    logic                     w_accept;
    logic [DATA_WIDTH-1:0]    w_beatData;
    logic [CHANNEL_WIDTH-1:0] w_beatChannel;
    logic                     w_beatSop;
    logic                     w_beatEop;

    // Pointer advance that wraps at the last real port, never reaching NUM_CHANNELS.
    function automatic logic [IDX_W-1:0] nextPort(input logic [IDX_W-1:0] p);
        if (int'(p) >= NUM_CHANNELS - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        int idx;
        w_sel      = '0;
        w_anyValid = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(r_rrPtr) + k;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            if (!w_anyValid && in_valid[IDX_W'(idx)]) begin
                w_anyValid = 1'b1;
                w_sel      = IDX_W'(idx);
            end
        end
    end

    // While locked only the owner may move data, whether or not it is currently valid.
    assign w_port       = (r_state == LOCKED) ? r_owner : w_sel;
    assign w_grantValid = (r_state == LOCKED) | w_anyValid;

    always_comb begin
        in_ready = '0;
        if (w_grantValid) begin
            in_ready[w_port] = w_space;
        end
    end

    assign w_accept = in_valid[w_port] & in_ready[w_port];

    always_comb begin
        w_beatData = '0;
        for (int p = 0; p < NUM_CHANNELS; p++) begin
            if (IDX_W'(p) == w_port) begin
                w_beatData = in_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_beatSop     = in_startofpacket[w_port];
    assign w_beatEop     = in_endofpacket[w_port];
    assign w_beatChannel = CHANNEL_WIDTH'(w_port);

    // Owner is captured only on a multi-beat SOP; every packet end moves the pointer past its port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rrPtr <= '0;
        end else if (w_accept) begin
            unique case (r_state)
                IDLE: begin
                    if (w_beatSop && !w_beatEop) begin
                        r_state <= LOCKED;
                        r_owner <= w_sel;
                    end else begin
                        r_rrPtr <= nextPort(w_sel);
                    end
                end
                LOCKED: begin
                    if (w_beatEop) begin
                        r_state <= IDLE;
                        r_rrPtr <= nextPort(r_owner);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    trace_mgmt_skid_buffer #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CHANNEL_WIDTH(CHANNEL_WIDTH)
    ) u_outStage (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (w_grantValid & in_valid[w_port]),
        .in_ready         (w_space),
        .in_data          (w_beatData),
        .in_channel       (w_beatChannel),
        .in_startofpacket (w_beatSop),
        .in_endofpacket   (w_beatEop),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_channel      (out_channel),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket)
    );

endmodule

// File: tb/tb_trace_mgmt_channel_mux.sv
// Randomized bench for trace_mgmt_channel_mux: per-port packet generators feed the DUT
// while a transaction-level arbitration model with an expected-output queue predicts every cycle.
module tb_trace_mgmt_channel_mux;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_sop;
    logic [N-1:0]    in_eop;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_channel;
    logic            out_sop;
    logic            out_eop;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ch;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t expQ[$];
    bit    mLocked;
    int    mOwner;
    int    mPtr;

    int            remBeats[N];
    int            curLen[N];
    logic [DW-1:0] curData[N];
    logic          curSop[N];
    logic          curEop[N];

    int       lenMin;
    int       lenMax;
    int       validPct;
    int       readyMode;
    logic [N-1:0] reqMask;
    bit       strayOn;
    bit       toggleState;

    trace_mgmt_channel_mux #(
        .NUM_CHANNELS (N),
        .DATA_WIDTH   (DW),
        .CHANNEL_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_startofpacket (in_sop),
        .in_endofpacket   (in_eop),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_channel      (out_channel),
        .out_startofpacket(out_sop),
        .out_endofpacket  (out_eop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic makeBeat(input int p);
        curData[p] = DW'($urandom);
        curSop[p]  = (remBeats[p] == curLen[p]);
        curEop[p]  = (remBeats[p] == 1);
        if (strayOn && $urandom_range(0, 7) == 0) begin
            curSop[p] = ~curSop[p];
        end
    endtask

    task automatic newPacket(input int p);
        curLen[p]   = int'($urandom_range(lenMax, lenMin));
        remBeats[p] = curLen[p];
        makeBeat(p);
    endtask

    task automatic modelReset();
        expQ.delete();
        mLocked = 1'b0;
        mOwner  = 0;
        mPtr    = 0;
        for (int p = 0; p < N; p++) begin
            newPacket(p);
        end
    endtask

    task automatic applyStimulus();
        for (int p = 0; p < N; p++) begin
            in_valid[p]          = reqMask[p] && ($urandom_range(0, 99) < validPct);
            in_data[p*DW +: DW]  = curData[p];
            in_sop[p]            = curSop[p];
            in_eop[p]            = curEop[p];
        end
        toggleState = ~toggleState;
        case (readyMode)
            0:       out_ready = $urandom_range(0, 1) == 1;
            1:       out_ready = 1'b1;
            default: out_ready = toggleState;
        endcase
    endtask

    // Predicts grant, ready and output for the coming edge, then advances the model past it.
    task automatic modelCycle();
        int       sel;
        int       port;
        bit       any;
        bit       space;
        bit       accept;
        logic [N-1:0] expReady;
        beat_t    b;
        any   = 1'b0;
        sel   = 0;
        space = expQ.size() < 2;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mPtr + k) % N;
            if (!any && in_valid[c]) begin
                any = 1'b1;
                sel = c;
            end
        end
        port = mLocked ? mOwner : sel;
        expReady = '0;
        if (mLocked || any) begin
            expReady[port] = space;
        end
        checkOutput("in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkOutput("out_beat", 32'({out_data, out_channel, out_sop, out_eop}), 32'(expQ[0]));
        end
        accept = (mLocked || any) && in_valid[port] && space;
        if (expQ.size() != 0 && out_ready) begin
            void'(expQ.pop_front());
        end
        if (accept) begin
            b.data = curData[port];
            b.ch   = CW'(port);
            b.sop  = curSop[port];
            b.eop  = curEop[port];
            expQ.push_back(b);
            if (mLocked) begin
                if (b.eop) begin
                    mLocked = 1'b0;
                    mPtr    = (mOwner + 1) % N;
                end
            end else if (b.sop && !b.eop) begin
                mLocked = 1'b1;
                mOwner  = port;
            end else begin
                mPtr = (port + 1) % N;
            end
            remBeats[port]--;
            if (remBeats[port] == 0) begin
                newPacket(port);
            end else begin
                makeBeat(port);
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            applyStimulus();
            @(negedge clk);
            modelCycle();
        end
    endtask

    task automatic resetCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            applyStimulus();
            @(negedge clk);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
            checkOutput("rst_out_fields", 32'({out_data, out_channel, out_sop, out_eop}), 32'd0);
        end
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus();
        @(negedge clk);
        modelCycle();
    endtask

    initial begin
        bit found;
        reset_n     = 1'b0;
        toggleState = 1'b0;
        lenMin      = 1;
        lenMax      = 1;
        strayOn     = 1'b0;
        reqMask     = '1;
        validPct    = 100;
        readyMode   = 1;
        modelReset();
        applyStimulus();

        resetCycles(3);
        releaseReset();
        runCycles(1);
        checkOutput("first_valid", 32'(out_valid), 32'd1);
        checkOutput("first_channel", 32'(out_channel), 32'd0);

        // Round-robin of single-beat packets from every port.
        runCycles(20);

        // Five-beat packets from port 2 competing with port 1.
        reqMask = 4'b0110;
        lenMin  = 5;
        lenMax  = 5;
        runCycles(30);

        // Sixteen-beat packets under alternating backpressure.
        reqMask   = '1;
        lenMin    = 16;
        lenMax    = 16;
        readyMode = 2;
        runCycles(80);

        // Only ports 3 and 0 requesting, so the pointer must wrap.
        reqMask   = 4'b1001;
        lenMin    = 1;
        lenMax    = 1;
        readyMode = 1;
        runCycles(12);

        // Mixed random traffic with stray SOPs and random backpressure.
        reqMask   = '1;
        validPct  = 60;
        lenMin    = 1;
        lenMax    = 6;
        strayOn   = 1'b1;
        readyMode = 0;
        runCycles(1500);

        // Reset in the middle of a six-beat packet from port 1.
        reqMask   = 4'b0010;
        validPct  = 100;
        lenMin    = 6;
        lenMax    = 6;
        strayOn   = 1'b0;
        readyMode = 1;
        found     = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            runCycles(1);
            found = (curLen[1] == 6) && (remBeats[1] == 3);
        end
        if (!found) begin
            checkOutput("midrst_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        modelReset();
        resetCycles(2);
        releaseReset();
        reqMask  = '1;
        validPct = 70;
        lenMin   = 1;
        lenMax   = 6;
        readyMode = 0;
        runCycles(300);

        // Stop requesting and let everything drain.
        validPct  = 0;
        readyMode = 1;
        runCycles(10);
        checkOutput("drain_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
